// File: rtl/decode_issue_stage_pkg.sv
// rtl/decode_issue_stage_pkg.sv - shared opcodes, width defaults and control bundle for decode/issue
package decode_issue_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Which instruction field names the destination register.
    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/decode_issue_stage_instr_decoder.sv
// rtl/decode_issue_stage_instr_decoder.sv - combinational opcode decoder for the decode/issue stage
// Ports:
//   opcode   in   instr[31:26]
//   ctrl     out  control bundle (all zero for unsupported opcodes)
//   dest_sel out  destination field select (none for sw, beq, unsupported)
//   uses_rt  out  rt is a source operand (R-type, sw, beq)
//   illegal  out  opcode is unsupported
module instr_decoder
    import decode_issue_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output dest_sel_e  dest_sel,
    output logic       uses_rt,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_NONE;
        dest_sel = DEST_NONE;
        uses_rt  = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                dest_sel       = DEST_RD;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                dest_sel       = DEST_RT;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                dest_sel       = DEST_RT;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                uses_rt     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - ID stage: decode, load-use hazard detection and ID/EX register
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   instr_in, instr_valid          instruction from IF/ID and its valid flag
//   flush                          kill the instruction in ID (branch taken in EX)
//   ex_hold                        EX cannot accept; freeze ID/EX
//   rf_read_add1/2                 register file read addresses (rs, rt)
//   rf_read_data1/2                register file read data
//   stall_if                       hold PC and IF/ID this cycle
//   ex_*                           ID/EX register contents
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic              ex_hold,
    output logic [ADDR_W-1:0] rf_read_add1,
    output logic [ADDR_W-1:0] rf_read_add2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [5:0]        ex_funct,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_illegal
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] dest;
        logic [5:0]        funct;
        ctrl_t             ctrl;
        logic              illegal;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;

    ctrl_t     dec_ctrl;
    dest_sel_e dec_dest_sel;
    logic      dec_uses_rt;
    logic      dec_illegal;

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              hazard;

    instr_decoder u_instr_decoder (
        .opcode   (instr_in[31:26]),
        .ctrl     (dec_ctrl),
        .dest_sel (dec_dest_sel),
        .uses_rt  (dec_uses_rt),
        .illegal  (dec_illegal)
    );

    assign rs_addr = ADDR_W'(instr_in[25:21]);
    assign rt_addr = ADDR_W'(instr_in[20:16]);
    assign rd_addr = ADDR_W'(instr_in[15:11]);

    assign rf_read_add1 = rs_addr;
    assign rf_read_add2 = rt_addr;

    // Only a load sitting in EX can produce a value too late for the
    // instruction in ID; rs is always compared, rt only when it is a source.
    assign hazard = instr_valid & idex_q.valid & idex_q.ctrl.mem_read
                  & (idex_q.dest != '0)
                  & ((idex_q.dest == rs_addr) | (dec_uses_rt & (idex_q.dest == rt_addr)));

    // A flush discards the ID instruction, so there is nothing left to hold.
    assign stall_if = (hazard | ex_hold) & ~flush;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex_hold) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d = '0;
        end else begin
            idex_d.valid   = instr_valid;
            idex_d.rs_data = rf_read_data1;
            idex_d.rt_data = rf_read_data2;
            idex_d.imm     = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
            idex_d.funct   = instr_in[5:0];
            idex_d.ctrl    = instr_valid ? dec_ctrl : CTRL_NONE;
            idex_d.illegal = instr_valid & dec_illegal;
            case (dec_dest_sel)
                DEST_RD: idex_d.dest = rd_addr;
                DEST_RT: idex_d.dest = rt_addr;
                default: idex_d.dest = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid     = idex_q.valid;
    assign ex_rs_data   = idex_q.rs_data;
    assign ex_rt_data   = idex_q.rt_data;
    assign ex_imm       = idex_q.imm;
    assign ex_dest      = idex_q.dest;
    assign ex_funct     = idex_q.funct;
    assign ex_reg_write = idex_q.ctrl.reg_write;
    assign ex_mem_read  = idex_q.ctrl.mem_read;
    assign ex_mem_write = idex_q.ctrl.mem_write;
    assign ex_alu_src   = idex_q.ctrl.alu_src;
    assign ex_branch    = idex_q.ctrl.branch;
    assign ex_illegal   = idex_q.illegal;

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter DATA_W, default 32: register and data width.
REQ-002 Parameter ADDR_W, default 5: register address width (32 registers).
REQ-003 clk  input  1: single clock; all state updates on posedge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 instr_in  input  32: instruction from the IF/ID register.
REQ-006 instr_valid  input  1: instr_in holds a real instruction.
REQ-007 flush  input  1: branch taken in EX; kill the instruction in ID.
REQ-008 ex_hold  input  1: EX cannot accept; freeze the ID/EX register.
REQ-009 rf_read_add1, rf_read_add2  output  ADDR_W each: register file read addresses, combinational from instr_in[25:21] and [20:16].
REQ-010 rf_read_data1, rf_read_data2  input  DATA_W each: register file read data, valid before the next posedge.
REQ-011 stall_if  output  1: combinational; hold the PC and IF/ID this cycle.
REQ-012 ex_valid  output  1: the ID/EX register holds a live instruction.
REQ-013 ex_rs_data, ex_rt_data  output  DATA_W each: latched operands.
REQ-014 ex_imm  output  DATA_W: sign-extended instr[15:0].
REQ-015 ex_dest  output  ADDR_W: destination register.
REQ-016 ex_funct  output  6: instr[5:0].
REQ-017 ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch  output  1 each: control bits.
REQ-018 ex_illegal  output  1: the latched opcode was unsupported.

Function
REQ-019 Decode rules:
- opcode 0x00 (R-type): dest=rd, reg_write.
- 0x23 (lw): dest=rt, mem_read, reg_write, alu_src.
- 0x2B (sw): mem_write, alu_src.
- 0x08 (addi): dest=rt, reg_write, alu_src.
- 0x04 (beq): branch.
- Any other opcode: illegal=1 and all control bits 0.
REQ-020 Uses rt = R-type, sw or beq; uses rs = every supported opcode.
REQ-021 Load-use hazard = instr_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==rs, or ex_dest==rt when rt is used).
REQ-022 stall_if = (hazard | ex_hold) & !flush.
REQ-023 Per-posedge priority:
- flush: load a bubble.
- else ex_hold: keep all outputs unchanged.
- else hazard: load a bubble.
- else load the decoded instruction with ex_valid=instr_valid.
REQ-024 Bubble: ex_valid=0; all control bits, ex_illegal and ex_dest cleared; data fields don't-care but driven 0.
REQ-025 A decoded instruction with instr_valid=0 loads with all control bits forced to 0.
REQ-026 Latency: one cycle from instr_in to ex_* outputs; operands are taken from rf_read_data at that same edge.
REQ-027 A hazard lasts exactly one cycle: the bubble clears the ex_mem_read condition, and the held instruction issues on the next edge.
REQ-028 ex_dest==0 never raises a hazard.
REQ-029 flush together with hazard: the bubble is loaded and stall_if=0.

Reset
REQ-030 While rst=1, all ex_* outputs are 0 immediately, independent of clk.
REQ-031 The first posedge after rst deasserts loads normally.
REQ-032 An instruction in flight when reset asserts is discarded and is not reissued.

Structure
REQ-033 Shared package holds the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ), DATA_W/ADDR_W defaults, and the control-bundle struct typedef.
REQ-034 Combinational sub-module instr_decoder: instr in, control bundle plus uses_rt/illegal out; it is instantiated once.
REQ-035 No other state besides the ID/EX register.

Verification
REQ-036 Directed scenarios:
- add $3,$1,$2 with rf_read_data1=5 and rf_read_data2=7: next edge gives ex_valid=1, ex_rs_data=5, ex_rt_data=7, ex_dest=3, ex_reg_write=1.
- lw $4,8($1) followed by add $5,$4,$2: stall_if=1 for one cycle, one bubble, then the add issues with ex_dest=5.
- lw $0 followed by a dependent add: no stall.
- flush together with the hazard: bubble loaded, stall_if=0.
- ex_hold=1 for 3 cycles: ex_* outputs unchanged and stall_if=1 throughout.
- rst asserted mid-cycle: ex_valid=0 before the next edge.
- opcode 0x3F: ex_illegal=1 and all control bits 0.
